serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parameterised bit-serial adder/subtractor; sequential successor to the single-bit combinational adder used in the lab series.
- Accepts two WIDTH-bit operands on a start strobe. Processes one bit per clock through a single full-adder cell and a carry flip-flop.
- Presents a registered sum with carry-out and signed-overflow flags, plus a one-cycle done pulse.
- Sits between lab stimulus/switch logic and display/result registers.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled on rising edge of clk.
- sub  input  1  0 = A+B, 1 = A-B; captured with operands.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when sum/cout/ovf are updated.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  carry out of MSB. In sub mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rstn low, asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; operand shift registers, carry and bit counter cleared.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 is accepted.
    - Load opA=a, opB = sub ? ~b : b, carry=sub, count=0.
    - Go to RUN; busy=1 from E0.
  - RUN: each edge performs one bit step.
    - s = opA[0]^opB[0]^carry; carry <= majority(opA[0], opB[0], carry).
    - Shift s into the MSB of the partial-sum register; shift opA and opB right by 1; count++.
    - Record the carry into the MSB on the step where count==WIDTH-1.
    - On the WIDTH-th step (edge E0+WIDTH): sum <= completed partial sum, cout <= final carry, ovf <= carry_in_MSB ^ final carry, done <= 1, busy <= 0; go to DONE.
  - DONE: lasts one cycle with done=1; otherwise identical to IDLE.
    - start=1 here is accepted exactly as in IDLE, allowing back-to-back operations.
    - Otherwise return to IDLE with done <= 0.
- Latency: done is high for the cycle following edge E0+WIDTH, exactly WIDTH clocks after the accepting edge. Throughput is one result per WIDTH+1 clocks.
- start while busy=1 is ignored. Operands and sub captured at E0 are unaffected by later changes on a, b or sub.
- sum, cout and ovf change only at completion. Intermediate partial sums are never visible on the ports.
- Arithmetic is modulo 2^WIDTH; the result wraps with no saturation.
- Reset asserted mid-RUN aborts the operation with no done pulse; outputs go to reset values. After rstn deasserts, the first start is handled normally.
- Counter width is clog2(WIDTH+1) bits; it never exceeds WIDTH.

Test Plan:
- WIDTH=8, sub=0, a=100, b=55, start pulse -> busy high 8 cycles; done pulse 8 clocks after accept; sum=155, cout=0, ovf=1.
- sub=0, a=200, b=100 -> sum=44, cout=1, ovf=0. Then sub=1, a=5, b=7 -> sum=254, cout=0, ovf=0.
- sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1. Also sub=1, a=b=0x3C -> sum=0, cout=1, ovf=0.
- Start held high continuously with a/b changed mid-RUN -> first result uses values captured at accept; the second operation is accepted in the DONE cycle; results every 9 clocks.
- rstn pulsed low at bit step 4 of an operation -> busy=0 immediately, no done, sum/cout/ovf=0. A subsequent start of 1+1 -> sum=2.
- WIDTH=2 and WIDTH=16 builds, exhaustive/random operands against a reference model (a±b) -> sum, cout and ovf match; done latency equals WIDTH.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, one
// operand bit per clock, LSB first. Results appear on the ports only at
// completion, together with carry-out, overflow and a one-cycle done pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one bit step per clock, WIDTH steps in total; busy=1
// DONE  | single cycle with done=1; start here is accepted as in IDLE
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : gBadWidth
    $error("serial_adder: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] partial;
  logic             carry;
  logic [CntW-1:0]  count;
  logic             accept;
  logic             finalStep;
  logic             bitSum;
  logic             carryOut;

  // Subtraction reuses the adder: a + ~b + 1, the +1 entering as carry-in.
  assign accept    = start && (state != RUN);
  assign finalStep = (state == RUN) && (count == LastStep);
  assign bitSum    = opA[0] ^ opB[0] ^ carry;
  assign carryOut  = (opA[0] & opB[0]) | (opA[0] & carry) | (opB[0] & carry);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; DONE behaves like IDLE apart from the done flag.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (count == LastStep) stateNext = DONE;
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture, bit stepping, and result registers updated on the last step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      opA     <= '0;
      opB     <= '0;
      partial <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      opA     <= a;
      opB     <= sub ? ~b : b;
      partial <= '0;
      carry   <= sub;
      count   <= '0;
    end else if (state == RUN) begin
      opA     <= {1'b0, opA[WIDTH-1:1]};
      opB     <= {1'b0, opB[WIDTH-1:1]};
      partial <= {bitSum, partial[WIDTH-1:1]};
      carry   <= carryOut;
      count   <= count + CntW'(1);
      if (finalStep) begin
        // carry at this point is the carry into the MSB.
        sum  <= {bitSum, partial[WIDTH-1:1]};
        cout <= carryOut;
        ovf  <= carry ^ carryOut;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8, 2 and 16 instances, checked
// against an arithmetic reference model of signed/unsigned add and subtract.
module tb_serial_adder;

  logic        clk;
  logic        rstn;
  logic        startReq;
  logic        subIn;
  logic [31:0] aBus;
  logic [31:0] bBus;
  int          sel;

  logic        start8, start2, start16;
  logic        busy8, busy2, busy16;
  logic        done8, done2, done16;
  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [15:0] sum16;
  logic        cout8, cout2, cout16;
  logic        ovf8, ovf2, ovf16;

  logic        obsBusy, obsDone, obsCout, obsOvf;
  logic [31:0] obsSum;

  int passCount = 0;
  int checkCount = 0;

  assign start8  = startReq && (sel == 8);
  assign start2  = startReq && (sel == 2);
  assign start16 = startReq && (sel == 16);

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .sub(subIn),
    .a(aBus[7:0]), .b(bBus[7:0]), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .sub(subIn),
    .a(aBus[1:0]), .b(bBus[1:0]), .busy(busy2), .done(done2),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rstn(rstn), .start(start16), .sub(subIn),
    .a(aBus[15:0]), .b(bBus[15:0]), .busy(busy16), .done(done16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  always_comb begin
    obsBusy = busy8;
    obsDone = done8;
    obsSum  = {24'b0, sum8};
    obsCout = cout8;
    obsOvf  = ovf8;
    case (sel)
      2: begin
        obsBusy = busy2; obsDone = done2; obsSum = {30'b0, sum2};
        obsCout = cout2; obsOvf = ovf2;
      end
      16: begin
        obsBusy = busy16; obsDone = done16; obsSum = {16'b0, sum16};
        obsCout = cout16; obsOvf = ovf16;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void refModel(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic sv, output logic [31:0] s, output logic c,
                                   output logic o);
    longint modv, ua, ub, sa, sb, r;
    modv = longint'(1) << w;
    ua = longint'(av) & (modv - 1);
    ub = longint'(bv) & (modv - 1);
    sa = (ua >= modv / 2) ? ua - modv : ua;
    sb = (ub >= modv / 2) ? ub - modv : ub;
    r  = sv ? ua - ub : ua + ub;
    s  = 32'(((r % modv) + modv) % modv);
    c  = sv ? (ua >= ub) : (r >= modv);
    r  = sv ? sa - sb : sa + sb;
    o  = (r < -(modv / 2)) || (r >= modv / 2);
  endfunction

  // Issue one operation, scramble inputs after accept, and wait for done.
  task automatic runOp(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, output int lat, output int busyCnt,
                       output bit sumMoved);
    logic [31:0] sumBefore;
    @(negedge clk);
    sel = w; aBus = av; bBus = bv; subIn = sv; startReq = 1'b1;
    sumBefore = obsSum;
    @(negedge clk);
    startReq = 1'b0; aBus = $urandom; bBus = $urandom; subIn = 1'($urandom);
    lat = 0; busyCnt = 0; sumMoved = 1'b0;
    while (!obsDone && lat < 100) begin
      if (obsBusy) busyCnt++;
      if (obsSum !== sumBefore) sumMoved = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    checkCount++;
    if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy8); else passCount++;
    checkCount++;
    if (done8 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done8); else passCount++;
    checkCount++;
    if (sum8 !== 8'h00) $display("FAIL reset_sum: got %0h expected 0", sum8); else passCount++;
    checkCount++;
    if ({cout8, ovf8} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {cout8, ovf8});
    else passCount++;
  endtask

  task automatic test_directed;
    logic [7:0] ta [5] = '{8'd100, 8'd200, 8'd5, 8'h80, 8'h3C};
    logic [7:0] tb [5] = '{8'd55,  8'd100, 8'd7, 8'h01, 8'h3C};
    logic       ts [5] = '{1'b0,   1'b0,   1'b1, 1'b1,  1'b1};
    logic [7:0] es [5] = '{8'd155, 8'd44,  8'd254, 8'h7F, 8'h00};
    logic       ec [5] = '{1'b0,   1'b1,   1'b0, 1'b1,  1'b1};
    logic       eo [5] = '{1'b1,   1'b0,   1'b0, 1'b1,  1'b0};
    int lat, busyCnt;
    bit moved;
    for (int i = 0; i < 5; i++) begin
      runOp(8, {24'b0, ta[i]}, {24'b0, tb[i]}, ts[i], lat, busyCnt, moved);
      checkCount++;
      if (lat !== 8) $display("FAIL dir%0d_latency: got %0d expected 8", i, lat); else passCount++;
      checkCount++;
      if (busyCnt !== 8) $display("FAIL dir%0d_busy_cycles: got %0d expected 8", i, busyCnt);
      else passCount++;
      checkCount++;
      if (moved) $display("FAIL dir%0d_sum_early: got changed expected stable", i); else passCount++;
      checkCount++;
      if (obsSum !== {24'b0, es[i]}) $display("FAIL dir%0d_sum: got %0h expected %0h", i, obsSum, es[i]);
      else passCount++;
      checkCount++;
      if (obsCout !== ec[i]) $display("FAIL dir%0d_cout: got %b expected %b", i, obsCout, ec[i]);
      else passCount++;
      checkCount++;
      if (obsOvf !== eo[i]) $display("FAIL dir%0d_ovf: got %b expected %b", i, obsOvf, eo[i]);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (obsDone !== 1'b0) $display("FAIL dir%0d_done_pulse: got %b expected 0", i, obsDone);
      else passCount++;
      checkCount++;
      if (obsSum !== {24'b0, es[i]}) $display("FAIL dir%0d_sum_hold: got %0h expected %0h", i, obsSum, es[i]);
      else passCount++;
    end
  endtask

  task automatic test_random(input int w, input int n);
    logic [31:0] mask, av, bv, es;
    logic sv, ec, eo;
    int lat, busyCnt;
    bit moved;
    mask = (32'h1 << w) - 32'h1;
    for (int i = 0; i < n; i++) begin
      av = $urandom & mask;
      bv = $urandom & mask;
      sv = 1'($urandom);
      refModel(w, av, bv, sv, es, ec, eo);
      runOp(w, av, bv, sv, lat, busyCnt, moved);
      checkCount++;
      if (lat !== w) $display("FAIL rnd%0d_latency: got %0d expected %0d", w, lat, w); else passCount++;
      checkCount++;
      if ({obsSum, obsCout, obsOvf} !== {es, ec, eo})
        $display("FAIL rnd%0d_result a=%0h b=%0h sub=%b: got sum=%0h cout=%b ovf=%b expected sum=%0h cout=%b ovf=%b",
                 w, av, bv, sv, obsSum, obsCout, obsOvf, es, ec, eo);
      else passCount++;
    end
  endtask

  task automatic test_exhaustive2;
    logic [31:0] es;
    logic ec, eo;
    int lat, busyCnt;
    bit moved;
    for (int av = 0; av < 4; av++)
      for (int bv = 0; bv < 4; bv++)
        for (int sv = 0; sv < 2; sv++) begin
          refModel(2, 32'(av), 32'(bv), 1'(sv), es, ec, eo);
          runOp(2, 32'(av), 32'(bv), 1'(sv), lat, busyCnt, moved);
          checkCount++;
          if (lat !== 2) $display("FAIL w2_latency: got %0d expected 2", lat); else passCount++;
          checkCount++;
          if ({obsSum, obsCout, obsOvf} !== {es, ec, eo})
            $display("FAIL w2_result a=%0d b=%0d sub=%0d: got sum=%0h cout=%b ovf=%b expected sum=%0h cout=%b ovf=%b",
                     av, bv, sv, obsSum, obsCout, obsOvf, es, ec, eo);
          else passCount++;
        end
  endtask

  task automatic test_back_to_back;
    logic [31:0] es;
    logic ec, eo;
    int lat, gap;
    @(negedge clk);
    sel = 8; aBus = 32'd30; bBus = 32'd40; subIn = 1'b0; startReq = 1'b1;
    @(negedge clk);
    aBus = 32'd9; bBus = 32'd250;
    lat = 0;
    while (!obsDone && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    refModel(8, 32'd30, 32'd40, 1'b0, es, ec, eo);
    checkCount++;
    if (lat !== 8) $display("FAIL b2b_first_latency: got %0d expected 8", lat); else passCount++;
    checkCount++;
    if ({obsSum, obsCout, obsOvf} !== {es, ec, eo})
      $display("FAIL b2b_first_result: got %0h/%b/%b expected %0h/%b/%b", obsSum, obsCout, obsOvf, es, ec, eo);
    else passCount++;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!obsDone && gap < 100);
    startReq = 1'b0;
    refModel(8, 32'd9, 32'd250, 1'b0, es, ec, eo);
    checkCount++;
    if (gap !== 9) $display("FAIL b2b_period: got %0d expected 9", gap); else passCount++;
    checkCount++;
    if ({obsSum, obsCout, obsOvf} !== {es, ec, eo})
      $display("FAIL b2b_second_result: got %0h/%b/%b expected %0h/%b/%b", obsSum, obsCout, obsOvf, es, ec, eo);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if ({obsBusy, obsDone} !== 2'b00) $display("FAIL b2b_idle_after: got %b expected 00", {obsBusy, obsDone});
    else passCount++;
  endtask

  task automatic test_reset_midrun;
    int lat, busyCnt;
    bit moved, sawDone;
    runOp(8, 32'd100, 32'd55, 1'b0, lat, busyCnt, moved);
    @(negedge clk);
    sel = 8; aBus = 32'hFF; bBus = 32'h0F; subIn = 1'b0; startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkCount++;
    if (busy8 !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy8); else passCount++;
    checkCount++;
    if ({sum8, cout8, ovf8} !== 10'b0)
      $display("FAIL midreset_outputs: got %0h/%b/%b expected 0/0/0", sum8, cout8, ovf8);
    else passCount++;
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) sawDone = 1'b1;
      if (i == 2) rstn = 1'b1;
    end
    checkCount++;
    if (sawDone) $display("FAIL midreset_no_done: got pulse expected none"); else passCount++;
    runOp(8, 32'd1, 32'd1, 1'b0, lat, busyCnt, moved);
    checkCount++;
    if (lat !== 8) $display("FAIL postreset_latency: got %0d expected 8", lat); else passCount++;
    checkCount++;
    if ({obsSum, obsCout, obsOvf} !== {32'd2, 1'b0, 1'b0})
      $display("FAIL postreset_result: got %0h/%b/%b expected 2/0/0", obsSum, obsCout, obsOvf);
    else passCount++;
  endtask

  initial begin
    rstn = 1'b0; startReq = 1'b0; subIn = 1'b0;
    aBus = '0; bBus = '0; sel = 8;
    repeat (3) @(negedge clk);
    test_reset;
    rstn = 1'b1;
    test_directed;
    test_random(8, 40);
    test_back_to_back;
    test_reset_midrun;
    test_exhaustive2;
    test_random(16, 30);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
